// File: rtl/fpu_pkg.sv
// Shared binary32 format constants, the unpacked operand view and classification helpers.
package fpu_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Subnormals share exp==0 with zero and are flushed, so both classify as zero.
   function automatic logic is_zero(input fp32_t x);
      return x.exp == '0;
   endfunction

   function automatic logic is_inf(input fp32_t x);
      return (x.exp == '1) && (x.frac == '0);
   endfunction

   function automatic logic is_nan(input fp32_t x);
      return (x.exp == '1) && (x.frac != '0);
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// 27-bit leading-zero counter used to renormalise the significand after subtraction.
module fpu_lzc (
   input  logic [26:0] value,
   output logic [4:0]  count
);

   logic found;

   always_comb begin
      count = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found) begin
            if (value[i]) found = 1'b1;
            else          count = count + 5'd1;
         end
      end
   end

endmodule

// File: rtl/fpu_wrapper.sv
// Combinational binary32 adder/subtracter, round-to-nearest-even, with subnormals flushed to zero.
module fpu_wrapper
   import fpu_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        sub,
   output logic [31:0] OUT,
   output logic        zflag
);

   localparam logic signed [9:0] EXP_LIMIT = 10'(2 * BIAS + 1);

   // No state is held, so the clock is only a structural connection.
   logic unused_clk;
   assign unused_clk = CLK;

   fp32_t fa, fb;
   logic  b_sign, swap, eff_sub, big_sign;
   logic [EXP_W-1:0]  big_exp, small_exp, exp_diff;
   logic [FRAC_W-1:0] big_frac, small_frac;

   assign fa       = A;
   assign fb       = B;
   assign b_sign   = fb.sign ^ sub;
   assign eff_sub  = fa.sign ^ b_sign;
   assign swap     = B[30:0] > A[30:0];
   assign big_sign = swap ? b_sign  : fa.sign;
   assign big_exp  = swap ? fb.exp  : fa.exp;
   assign big_frac = swap ? fb.frac : fa.frac;
   assign small_exp  = swap ? fa.exp  : fb.exp;
   assign small_frac = swap ? fa.frac : fb.frac;
   assign exp_diff   = big_exp - small_exp;

   // Significands carry three extra low bits: guard, round and sticky.
   logic [26:0] big_ext, small_ext, small_shr, shifted_out, small_al;

   assign big_ext   = {1'b1, big_frac, 3'b000};
   assign small_ext = {1'b1, small_frac, 3'b000};

   always_comb begin
      small_shr   = small_ext >> exp_diff;
      shifted_out = small_ext & ~({27{1'b1}} << exp_diff);
      if (exp_diff >= 8'd26) small_al = 27'd1;
      else                   small_al = {small_shr[26:1], small_shr[0] | (|shifted_out)};
   end

   logic [27:0] sum;
   logic [26:0] diff_mag;
   logic [4:0]  lz;

   assign sum      = {1'b0, big_ext} + {1'b0, small_al};
   assign diff_mag = big_ext - small_al;

   fpu_lzc u_lzc (
      .value (diff_mag),
      .count (lz)
   );

   logic [26:0]       norm_m;
   logic signed [9:0] norm_exp;
   logic              cancel;

   always_comb begin
      norm_m   = '0;
      norm_exp = '0;
      cancel   = 1'b0;
      if (!eff_sub) begin
         if (sum[27]) begin
            norm_m   = {sum[27:2], sum[1] | sum[0]};
            norm_exp = {2'b00, big_exp} + 10'd1;
         end else begin
            norm_m   = sum[26:0];
            norm_exp = {2'b00, big_exp};
         end
      end else begin
         cancel   = (diff_mag == '0);
         norm_m   = diff_mag << lz;
         norm_exp = {2'b00, big_exp} - {5'b00000, lz};
      end
   end

   logic              round_inc;
   logic [24:0]       rounded;
   logic [FRAC_W-1:0] res_frac;
   logic signed [9:0] res_exp;

   assign round_inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
   assign rounded   = {1'b0, norm_m[26:3]} + {24'd0, round_inc};

   always_comb begin
      if (rounded[24]) begin
         res_frac = rounded[23:1];
         res_exp  = norm_exp + 10'sd1;
      end else begin
         res_frac = rounded[22:0];
         res_exp  = norm_exp;
      end
   end

   // Specials and zero operands take precedence over the arithmetic path.
   logic [31:0] result;

   always_comb begin
      if (is_nan(fa) || is_nan(fb))
         result = QNAN;
      else if (is_inf(fa) && is_inf(fb))
         result = eff_sub ? QNAN : {fa.sign, 8'hFF, 23'd0};
      else if (is_inf(fa))
         result = {fa.sign, 8'hFF, 23'd0};
      else if (is_inf(fb))
         result = {b_sign, 8'hFF, 23'd0};
      else if (is_zero(fa) && is_zero(fb))
         result = 32'h0;
      else if (is_zero(fa))
         result = {b_sign, B[30:0]};
      else if (is_zero(fb))
         result = A;
      else if (eff_sub && cancel)
         result = 32'h0;
      else if (res_exp <= 10'sd0)
         result = {big_sign, 31'd0};
      else if (res_exp >= EXP_LIMIT)
         result = {big_sign, 8'hFF, 23'd0};
      else
         result = {big_sign, res_exp[7:0], res_frac};
   end

   assign OUT   = RST ? 32'h0 : result;
   assign zflag = (OUT[30:0] == 31'd0);

endmodule

// File: tb/tb_fpu_wrapper.sv
// Directed-vector bench for fpu_wrapper with hand-computed binary32 results.
module tb_fpu_wrapper;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] A   = 32'h0;
   logic [31:0] B   = 32'h0;
   logic        sub = 1'b0;
   logic [31:0] OUT;
   logic        zflag;

   int compared   = 0;
   int mismatched = 0;

   always #5 CLK = ~CLK;

   fpu_wrapper dut (
      .CLK   (CLK),
      .RST   (RST),
      .A     (A),
      .B     (B),
      .sub   (sub),
      .OUT   (OUT),
      .zflag (zflag)
   );

   // Drive away from the rising edge and let the combinational path settle.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge CLK);
      A   = a;
      B   = b;
      sub = s;
      #2;
   endtask

   task automatic test_reset();
      apply(32'h400CCCCC, 32'h3F8CCCCC, 1'b0);
      compared++;
      if (OUT !== 32'h0 || zflag !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_hold: OUT=%h zflag=%b expected 00000000 1", OUT, zflag);
      end
      RST = 1'b0;
      #2;
   endtask

   task automatic test_add();
      apply(32'h400CCCCC, 32'h3F8CCCCC, 1'b0);
      compared++;
      if (OUT !== 32'h40533332 || zflag !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL add_basic: OUT=%h zflag=%b expected 40533332 0", OUT, zflag);
      end
      apply(32'h00000001, 32'h3F800000, 1'b0);
      compared++;
      if (OUT !== 32'h3F800000) begin
         mismatched++;
         $display("[TB] FAIL add_subnormal_flush: OUT=%h expected 3f800000", OUT);
      end
   endtask

   task automatic test_sub();
      apply(32'h069C43F3, 32'h0348817C, 1'b1);
      compared++;
      if (OUT !== 32'h069AB2F0) begin
         mismatched++;
         $display("[TB] FAIL sub_sticky: OUT=%h expected 069ab2f0", OUT);
      end
      apply(32'h3E800000, 32'h3F400000, 1'b1);
      compared++;
      if (OUT !== 32'hBF000000) begin
         mismatched++;
         $display("[TB] FAIL sub_sign_flip: OUT=%h expected bf000000", OUT);
      end
      apply(32'h3F800000, 32'h3F800000, 1'b1);
      compared++;
      if (OUT !== 32'h0 || zflag !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL sub_cancel: OUT=%h zflag=%b expected 00000000 1", OUT, zflag);
      end
   endtask

   task automatic test_zero();
      apply(32'h0, 32'h823374BC, 1'b1);
      compared++;
      if (OUT !== 32'h023374BC) begin
         mismatched++;
         $display("[TB] FAIL zero_minus_neg: OUT=%h expected 023374bc", OUT);
      end
      apply(32'h0, 32'h3F8CCCCC, 1'b1);
      compared++;
      if (OUT !== 32'hBF8CCCCC) begin
         mismatched++;
         $display("[TB] FAIL zero_minus_pos: OUT=%h expected bf8ccccc", OUT);
      end
      for (int s = 0; s < 2; s++) begin
         apply(32'h0, 32'h0, s[0]);
         compared++;
         if (OUT !== 32'h0 || zflag !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL both_zero_sub%0d: OUT=%h zflag=%b expected 00000000 1", s, OUT, zflag);
         end
      end
   endtask

   task automatic test_neg();
      apply(32'hC03EF34D, 32'hC2C9DAEE, 1'b1);
      compared++;
      if (OUT !== 32'h42C3E354) begin
         mismatched++;
         $display("[TB] FAIL neg_sub: OUT=%h expected 42c3e354", OUT);
      end
      apply(32'hCAA751CC, 32'hC91B912D, 1'b0);
      compared++;
      if (OUT !== 32'hCABAC3F2) begin
         mismatched++;
         $display("[TB] FAIL neg_add: OUT=%h expected cabac3f2", OUT);
      end
      apply(32'hC1700009, 32'hC060001E, 1'b0);
      compared++;
      if (OUT !== 32'hC1940008) begin
         mismatched++;
         $display("[TB] FAIL neg_add_carry: OUT=%h expected c1940008", OUT);
      end
   endtask

   task automatic test_special();
      apply(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
      compared++;
      if (OUT !== 32'h7F800000 || zflag !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL overflow_inf: OUT=%h zflag=%b expected 7f800000 0", OUT, zflag);
      end
      apply(32'h7FC12345, 32'h3F800000, 1'b0);
      compared++;
      if (OUT !== 32'h7FC00000) begin
         mismatched++;
         $display("[TB] FAIL nan_in: OUT=%h expected 7fc00000", OUT);
      end
      apply(32'h7F800000, 32'h7F800000, 1'b1);
      compared++;
      if (OUT !== 32'h7FC00000) begin
         mismatched++;
         $display("[TB] FAIL inf_minus_inf: OUT=%h expected 7fc00000", OUT);
      end
      apply(32'h3F800000, 32'h7F800000, 1'b1);
      compared++;
      if (OUT !== 32'hFF800000) begin
         mismatched++;
         $display("[TB] FAIL inf_sign: OUT=%h expected ff800000", OUT);
      end
   endtask

   task automatic test_reset_mid();
      apply(32'h400CCCCC, 32'h3F8CCCCC, 1'b0);
      RST = 1'b1;
      #1;
      compared++;
      if (OUT !== 32'h0 || zflag !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_assert: OUT=%h zflag=%b expected 00000000 1", OUT, zflag);
      end
      RST = 1'b0;
      #1;
      compared++;
      if (OUT !== 32'h40533332 || zflag !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_release: OUT=%h zflag=%b expected 40533332 0", OUT, zflag);
      end
   endtask

   initial begin
      $display("[TB] starting fpu_wrapper directed tests");
      test_reset();
      test_add();
      test_sub();
      test_zero();
      test_neg();
      test_special();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
